// File: rtl/trng_capture_pkg.sv
// Shared state encoding and word-geometry helpers for the TRNG capture controller.
// Word width is derived from ring count and sample width so each source owns whole byte lanes.
package trng_capture_pkg;

  typedef enum logic [1:0] {
    ST_RESET_SRC = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_FILL      = 2'd2,
    ST_DRAIN     = 2'd3
  } state_t;

  function automatic int calc_bps(input int src_width);
    return (src_width + 7) / 8;
  endfunction

  function automatic int calc_w(input int nsrc, input int src_width);
    return nsrc * calc_bps(src_width) * 8;
  endfunction

endpackage

// File: rtl/trng_capture_ram.sv
// Single-port capture buffer, DEPTH x W, registered read (1-cycle latency).
// No flow control: the controller never writes and reads in the same phase.
module trng_capture_ram #(
  parameter int DEPTH_WIDTH = 10,
  parameter int W           = 32
) (
  input  logic                   i_clk,
  input  logic                   we,
  input  logic [DEPTH_WIDTH-1:0] addr,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata
);

  logic [W-1:0] mem [2**DEPTH_WIDTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/trng_capture_ctrl.sv
// Ring-source reset, buffer fill (raw or XOR-folded), then byte dump; first byte 1 cycle into DRAIN.
// Output holds o_dat/o_valid while i_ready is low, sustains 1 byte/cycle when ready.
module trng_capture_ctrl
  import trng_capture_pkg::*;
#(
  parameter int NSRC           = 4,
  parameter int SRC_WIDTH      = 7,
  parameter int DEPTH_WIDTH    = 10,
  parameter int RESET_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int RESEED_EVERY   = 64,
  parameter int DUMP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_mode,
  input  logic [NSRC*SRC_WIDTH-1:0] i_sampled,
  output logic                      o_src_reset,
  output logic [7:0]                o_dat,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DUMP_CNT_WIDTH-1:0] o_dump_cnt,
  output logic [1:0]                o_state
);

  localparam int BPS        = calc_bps(SRC_WIDTH);
  localparam int W          = calc_w(NSRC, SRC_WIDTH);
  localparam int BPW        = W / 8;
  localparam int LANE       = BPS * 8;
  localparam int PAD        = LANE - SRC_WIDTH;
  localparam int CYC_MAX    = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W      = $clog2(CYC_MAX + 1);
  localparam int FC_W       = $clog2(W);
  localparam int BI_W       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int RESEED_DIV = (RESEED_EVERY == 0) ? 1 : RESEED_EVERY;

  state_t                    state, state_d;
  logic [CYC_W-1:0]          cyc_cnt;
  logic                      mode_q;
  logic [DEPTH_WIDTH-1:0]    wr_addr, rd_addr, rd_addr_nxt, ram_addr;
  logic [FC_W-1:0]           fold_cnt;
  logic [W-2:0]              fold_word;
  logic [W-1:0]              fold_nxt, raw_word, ram_wdata, ram_rdata;
  logic [BI_W-1:0]           byte_idx;
  logic [7:0]                rd_byte;
  logic                      primed, ram_we, xfer, byte_last, last_xfer, reseed;
  logic [DUMP_CNT_WIDTH-1:0] dump_nxt;

  always_comb begin
    raw_word = '0;
    for (int k = 0; k < NSRC; k++) begin
      raw_word[k*LANE +: LANE] = LANE'(i_sampled[k*SRC_WIDTH +: SRC_WIDTH]) << PAD;
    end
  end

  assign fold_nxt  = {fold_word, ^i_sampled};
  assign ram_we    = (state == ST_FILL) && (!mode_q || (fold_cnt == FC_W'(W - 1)));
  assign ram_wdata = mode_q ? fold_nxt : raw_word;

  // Reads run one word ahead: addressing with the next pointer keeps ram_rdata == mem[rd_addr].
  assign xfer      = o_valid && i_ready;
  assign byte_last = (byte_idx == BI_W'(BPW - 1));
  assign last_xfer = xfer && byte_last && (rd_addr == {DEPTH_WIDTH{1'b1}});
  assign dump_nxt  = o_dump_cnt + DUMP_CNT_WIDTH'(1);
  assign reseed    = (RESEED_EVERY != 0) && ((32'(dump_nxt) % 32'(RESEED_DIV)) == 32'd0);

  always_comb begin
    rd_addr_nxt = rd_addr;
    if (state == ST_DRAIN && xfer && byte_last) rd_addr_nxt = rd_addr + DEPTH_WIDTH'(1);
  end

  assign ram_addr = (state == ST_FILL) ? wr_addr : rd_addr_nxt;

  always_comb begin
    rd_byte = '0;
    for (int b = 0; b < BPW; b++) begin
      if (byte_idx == BI_W'(b)) rd_byte = ram_rdata[b*8 +: 8];
    end
  end

  trng_capture_ram #(
    .DEPTH_WIDTH(DEPTH_WIDTH),
    .W          (W)
  ) u_ram (
    .i_clk(i_clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_RESET_SRC;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_RESET_SRC:
        if (cyc_cnt == CYC_W'(RESET_CYCLES - 1))
          state_d = (SETTLE_CYCLES == 0) ? ST_FILL : ST_SETTLE;
      ST_SETTLE:
        if (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1)) state_d = ST_FILL;
      ST_FILL:
        if (ram_we && (wr_addr == {DEPTH_WIDTH{1'b1}})) state_d = ST_DRAIN;
      ST_DRAIN:
        if (last_xfer) state_d = reseed ? ST_RESET_SRC : ST_FILL;
      default: state_d = ST_RESET_SRC;
    endcase
  end

  always_comb begin
    o_src_reset = (state == ST_RESET_SRC);
    o_valid     = (state == ST_DRAIN) && primed;
    o_dat       = o_valid ? rd_byte : 8'd0;
    o_state     = state;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc_cnt    <= '0;
      mode_q     <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      fold_cnt   <= '0;
      fold_word  <= '0;
      byte_idx   <= '0;
      primed     <= 1'b0;
      o_dump_cnt <= '0;
    end else begin
      if (state_d != state) cyc_cnt <= '0;
      else if (state == ST_RESET_SRC || state == ST_SETTLE) cyc_cnt <= cyc_cnt + CYC_W'(1);

      if (state_d == ST_FILL && state != ST_FILL) mode_q <= i_mode;

      // A complete fill always leaves wr_addr and fold_cnt wrapped back to zero.
      if (state == ST_FILL) begin
        fold_word <= fold_nxt[W-2:0];
        if (mode_q) fold_cnt <= (fold_cnt == FC_W'(W - 1)) ? '0 : fold_cnt + FC_W'(1);
        if (ram_we) wr_addr <= wr_addr + DEPTH_WIDTH'(1);
      end

      if (state == ST_DRAIN) begin
        rd_addr <= rd_addr_nxt;
        if (xfer) byte_idx <= byte_last ? '0 : byte_idx + BI_W'(1);
      end

      primed <= (state == ST_DRAIN) && (state_d == ST_DRAIN);

      if (last_xfer) o_dump_cnt <= dump_nxt;
    end
  end

endmodule
